// File: rtl/mvm_stream_driver_if.sv
// mvm_stream_driver_if: element stream in, multiplier ena/done port, result stream out.
interface mvm_stream_driver_if #(
   parameter int N     = 3,
   parameter int WIDTH = 8
);
   logic                   in_valid;
   logic                   in_ready;
   logic [WIDTH-1:0]       in_data;
   logic                   mvm_ena;
   logic [N*N*WIDTH-1:0]   mvm_matrix_a;
   logic [N*WIDTH-1:0]     mvm_vector_b;
   logic [N*WIDTH-1:0]     mvm_vector_c;
   logic                   mvm_done;
   logic                   out_valid;
   logic                   out_ready;
   logic [WIDTH-1:0]       out_data;
   logic                   out_last;
   logic                   busy;
   logic                   err;
   modport master (
      output in_valid, in_data, mvm_vector_c, mvm_done, out_ready,
      input  in_ready, mvm_ena, mvm_matrix_a, mvm_vector_b, out_valid, out_data, out_last, busy, err
   );
   modport slave (
      input  in_valid, in_data, mvm_vector_c, mvm_done, out_ready,
      output in_ready, mvm_ena, mvm_matrix_a, mvm_vector_b, out_valid, out_data, out_last, busy, err
   );
endinterface

// File: rtl/mvm_stream_driver.sv
// mvm_stream_driver: loads A then b from a stream, runs the multiplier via ena/done, streams c out.
// MVM_TIMEOUT_EN adds a WAIT watchdog that forces a zero result and raises err.
module mvm_stream_driver #(
   parameter int N     = 3,
   parameter int WIDTH = 8
`ifdef MVM_TIMEOUT_EN
   , parameter int TIMEOUT_CYCLES = 64
`endif
) (
   input logic clk,
   input logic rst,
   mvm_stream_driver_if.slave bus
);
   localparam int NE = N*N + N;
   localparam int CW = $clog2(NE);
   typedef enum logic [1:0] {LOAD, START, WAIT, DRAIN} state_t;
   state_t                 state_q;
   logic [CW-1:0]          cnt_q;
   logic [CW-1:0]          idx_q;
   logic [N*N*WIDTH-1:0]   a_q;
   logic [N*WIDTH-1:0]     b_q;
   logic [N*WIDTH-1:0]     res_q;
   logic [WIDTH-1:0]       od_q;
   logic                   done_q;
   logic                   ena_q;
   logic                   ov_q;
   logic                   last_q;
   logic                   rise;
   logic                   to_hit;
   assign rise = bus.mvm_done & ~done_q;
`ifdef MVM_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] tmr_q;
   logic          err_q;
   assign to_hit  = tmr_q == TW'(TIMEOUT_CYCLES - 1);
   assign bus.err = err_q;
`else
   assign to_hit  = 1'b0;
   assign bus.err = 1'b0;
`endif
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= LOAD;
         cnt_q   <= '0;
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         od_q    <= '0;
         done_q  <= 1'b0;
         ena_q   <= 1'b0;
         ov_q    <= 1'b0;
         last_q  <= 1'b0;
`ifdef MVM_TIMEOUT_EN
         tmr_q   <= '0;
         err_q   <= 1'b0;
`endif
      end else begin
         done_q <= bus.mvm_done;
         case (state_q)
            LOAD: if (bus.in_valid) begin
               if (cnt_q < CW'(N*N))
                  a_q[(N*N - int'(cnt_q))*WIDTH-1 -: WIDTH] <= bus.in_data;
               else
                  b_q[(NE - int'(cnt_q))*WIDTH-1 -: WIDTH] <= bus.in_data;
`ifdef MVM_TIMEOUT_EN
               err_q <= 1'b0;
`endif
               if (cnt_q == CW'(NE - 1)) begin
                  cnt_q   <= '0;
                  ena_q   <= 1'b1;
                  state_q <= START;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            START: begin
               ena_q   <= 1'b0;
               state_q <= WAIT;
`ifdef MVM_TIMEOUT_EN
               tmr_q   <= '0;
`endif
            end
            // A real done edge wins over a watchdog expiry in the same cycle
            WAIT: if (rise | to_hit) begin
               res_q   <= rise ? bus.mvm_vector_c << WIDTH : '0;
               od_q    <= rise ? bus.mvm_vector_c[N*WIDTH-1 -: WIDTH] : '0;
               ov_q    <= 1'b1;
               idx_q   <= '0;
               last_q  <= N == 1;
               state_q <= DRAIN;
`ifdef MVM_TIMEOUT_EN
               err_q   <= ~rise;
            end else begin
               tmr_q   <= tmr_q + 1'b1;
`endif
            end
            DRAIN: if (bus.out_ready) begin
               if (last_q) begin
                  ov_q    <= 1'b0;
                  last_q  <= 1'b0;
                  state_q <= LOAD;
               end else begin
                  od_q   <= res_q[N*WIDTH-1 -: WIDTH];
                  res_q  <= res_q << WIDTH;
                  idx_q  <= idx_q + 1'b1;
                  last_q <= idx_q == CW'(N - 2);
               end
            end
            default: state_q <= LOAD;
         endcase
      end
   end
   assign bus.in_ready     = state_q == LOAD;
   assign bus.busy         = state_q != LOAD;
   assign bus.mvm_ena      = ena_q;
   assign bus.mvm_matrix_a = a_q;
   assign bus.mvm_vector_b = b_q;
   assign bus.out_valid    = ov_q;
   assign bus.out_data     = od_q;
   assign bus.out_last     = last_q;
endmodule

// File: tb/tb_mvm_stream_driver.sv
// tb_mvm_stream_driver: directed vectors against a behavioural multiplier stub with forceable done.
module tb_mvm_stream_driver;
   localparam int N = 3;
   localparam int W = 8;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   mvm_stream_driver_if #(.N(N), .WIDTH(W)) bus();
   mvm_stream_driver #(.N(N), .WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));
   logic           core_auto = 1'b1;
   logic           force_done = 1'b0;
   logic           core_done = 1'b0;
   int             dly = 0;
   logic [N*W-1:0] core_c;
   always_comb begin
      core_c = '0;
      for (int i = 0; i < N; i++) begin
         int s;
         s = 0;
         for (int j = 0; j < N; j++)
            s += $signed(bus.mvm_matrix_a[(N*N - N*i - j)*W-1 -: W]) * $signed(bus.mvm_vector_b[(N - j)*W-1 -: W]);
         core_c[(N - i)*W-1 -: W] = s[W-1:0];
      end
   end
   always @(posedge clk) begin
      if (bus.mvm_ena) dly <= 3;
      else if (dly != 0) dly <= dly - 1;
      core_done <= dly == 1;
   end
   assign bus.mvm_vector_c = core_c;
   assign bus.mvm_done     = core_auto ? core_done : force_done;
   typedef struct {
      int a[9];
      int b[3];
      int e[3];
      bit gap;
      bit tog;
   } vec_t;
   vec_t tv[4];
   int n_chk = 0;
   int n_fail = 0;
   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask
   task automatic feed(input int a[9], input int b[3], input bit gap);
      for (int k = 0; k < 12; k++) begin
         int  cyc;
         bit  acc;
         cyc = 0;
         acc = 1'b0;
         if (gap) repeat ($urandom_range(0, 2)) begin
            bus.in_valid = 1'b0;
            @(negedge clk);
         end
         bus.in_valid = 1'b1;
         bus.in_data  = W'(k < 9 ? a[k] : b[k-9]);
         while (!acc && cyc < 50) begin
            acc = bus.in_ready;
            cyc++;
            @(negedge clk);
         end
         if (!acc) chk("in_accept", 0, 1);
      end
      bus.in_valid = 1'b0;
   endtask
   task automatic collect(input int e[3], input bit tog, input int ena_exp);
      int got;
      int cyc;
      int ena;
      got = 0;
      cyc = 0;
      ena = 0;
      while (got < 3 && cyc < 300) begin
         if (bus.mvm_ena) ena++;
         if (bus.busy) chk("in_ready_busy", int'(bus.in_ready), 0);
         bus.out_ready = tog ? (cyc % 2 == 0) : 1'b1;
         if (bus.out_valid && bus.out_ready) begin
            chk("out_data", int'($signed(bus.out_data)), e[got]);
            chk("out_last", int'(bus.out_last), int'(got == 2));
            got++;
         end
         cyc++;
         @(negedge clk);
      end
      if (got < 3) chk("drain_timeout", got, 3);
      chk("ena_pulses", ena, ena_exp);
      chk("valid_after_last", int'(bus.out_valid), 0);
      chk("in_ready_after_last", int'(bus.in_ready), 1);
      bus.out_ready = 1'b0;
   endtask
   initial begin
      int n;
      int z[3];
      z = '{0, 0, 0};
      tv[0].a = '{1, 2, 3, 4, 5, 6, 7, 8, 9}; tv[0].b = '{1, 2, 3};   tv[0].e = '{14, 32, 50}; tv[0].gap = 0; tv[0].tog = 0;
      tv[1].a = '{1, 0, 0, 0, 1, 0, 0, 0, 1}; tv[1].b = '{2, 7, 99};  tv[1].e = '{2, 7, 99};   tv[1].gap = 0; tv[1].tog = 1;
      tv[2].a = '{1, 2, 3, 4, 5, 6, 7, 8, 9}; tv[2].b = '{0, 0, 0};   tv[2].e = '{0, 0, 0};    tv[2].gap = 1; tv[2].tog = 0;
      tv[3].a = '{1, 0, 0, 0, 1, 0, 0, 0, 1}; tv[3].b = '{-4, 9, 3};  tv[3].e = '{-4, 9, 3};   tv[3].gap = 0; tv[3].tog = 0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_in_ready", int'(bus.in_ready), 1);
      chk("rst_out_valid", int'(bus.out_valid), 0);
      chk("rst_ena", int'(bus.mvm_ena), 0);
      chk("rst_err", int'(bus.err), 0);
      chk("rst_out_data", int'(bus.out_data), 0);
      rst = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         if (i == 3) begin
            // done held high through START must not count as an edge
            core_auto  = 1'b0;
            force_done = 1'b1;
            feed(tv[0].a, tv[0].b, 1'b0);
            repeat (10) @(negedge clk);
            chk("tc4_no_exit", int'(bus.out_valid), 0);
            chk("tc4_busy", int'(bus.busy), 1);
            force_done = 1'b0;
            repeat (3) @(negedge clk);
            chk("tc4_still_wait", int'(bus.out_valid), 0);
            force_done = 1'b1;
            @(negedge clk);
            chk("tc4_exit", int'(bus.out_valid), 1);
            collect(tv[0].e, 1'b0, 0);
            core_auto  = 1'b1;
            force_done = 1'b0;
            feed(tv[1].a, tv[1].b, 1'b0);
            bus.out_ready = 1'b1;
            n = 0;
            while (!bus.out_valid && n < 50) begin
               n++;
               @(negedge clk);
            end
            chk("tc5_c0", int'($signed(bus.out_data)), 2);
            @(negedge clk);
            chk("tc5_c1", int'($signed(bus.out_data)), 7);
            rst = 1'b1;
            #1;
            chk("tc5_valid", int'(bus.out_valid), 0);
            chk("tc5_busy", int'(bus.busy), 0);
            chk("tc5_data", int'(bus.out_data), 0);
            chk("tc5_last", int'(bus.out_last), 0);
            chk("tc5_a00", int'(bus.mvm_matrix_a[71:64]), 0);
            bus.out_ready = 1'b0;
            @(negedge clk);
            rst = 1'b0;
            @(negedge clk);
         end
         feed(tv[i].a, tv[i].b, tv[i].gap);
         collect(tv[i].e, tv[i].tog, 1);
         if (i == 0) begin
            chk("a00_slice", int'(bus.mvm_matrix_a[71:64]), 1);
            chk("a22_slice", int'(bus.mvm_matrix_a[7:0]), 9);
            chk("b0_slice", int'(bus.mvm_vector_b[23:16]), 1);
            chk("b2_slice", int'(bus.mvm_vector_b[7:0]), 3);
            chk("err_idle", int'(bus.err), 0);
         end
      end
`ifdef MVM_TIMEOUT_EN
      core_auto  = 1'b0;
      force_done = 1'b0;
      feed(tv[0].a, tv[0].b, 1'b0);
      n = 0;
      while (!bus.out_valid && n < 200) begin
         n++;
         @(negedge clk);
      end
      chk("tc6_latency", n, 65);
      chk("tc6_err", int'(bus.err), 1);
      collect(z, 1'b0, 0);
      chk("tc6_err_sticky", int'(bus.err), 1);
      bus.in_valid = 1'b1;
      bus.in_data  = '0;
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk("tc6_err_clear", int'(bus.err), 0);
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
